// File: rtl/frame_sequencer.sv
// frame_sequencer: divides clk into sequencer steps and emits registered
// one-cycle quarter-frame and half-frame ticks plus a level frame IRQ.
//
// Ports:
//   clk           system clock, all logic on posedge
//   iReset_n      synchronous active-low reset
//   iWrite        register write strobe, latches iMode / iIrq_inhibit
//   iMode         0 = 4-step, 1 = 5-step (sampled with iWrite)
//   iIrq_inhibit  1 = frame IRQ disabled (sampled with iWrite)
//   iIrq_ack      single-cycle IRQ clear
//   oQuarter_clk  one-cycle envelope tick
//   oHalf_clk     one-cycle length/sweep tick (drives iSweep_clk)
//   oIrq          frame IRQ flag
//   oStep         index of the next step to fire (0..4)
//
// Optional macro FRAME_IMMEDIATE_CLK_EN: a write with iMode=1 also emits
// quarter and half ticks in the cycle following the write edge.
module frame_sequencer #(
    parameter int STEP_DIV = 7457,
    parameter int DIV_W    = 13
) (
    input  logic       clk,
    input  logic       iReset_n,
    input  logic       iWrite,
    input  logic       iMode,
    input  logic       iIrq_inhibit,
    input  logic       iIrq_ack,
    output logic       oQuarter_clk,
    output logic       oHalf_clk,
    output logic       oIrq,
    output logic [2:0] oStep
);

    typedef enum logic [2:0] {
        STEP0 = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4
    } step_e;

    logic [DIV_W-1:0] prescaler_q;
    step_e            step_q;
    step_e            step_d;
    logic             mode_q;
    logic             inhibit_q;
    logic             quarter_q;
    logic             half_q;
    logic             irq_q;

    logic             step_tick;
    logic             quarter_d;
    logic             half_d;
    logic             irq_set_d;

    assign step_tick = (prescaler_q == DIV_W'(STEP_DIV - 1));

    // Decode of what the current step emits when its tick arrives.
    always_comb begin
        step_d    = STEP0;
        quarter_d = 1'b0;
        half_d    = 1'b0;
        irq_set_d = 1'b0;
        case (step_q)
            STEP0: begin
                quarter_d = 1'b1;
                step_d    = STEP1;
            end
            STEP1: begin
                quarter_d = 1'b1;
                half_d    = 1'b1;
                step_d    = STEP2;
            end
            STEP2: begin
                quarter_d = 1'b1;
                step_d    = STEP3;
            end
            STEP3: begin
                if (mode_q) begin
                    // 5-step mode: step3 is silent
                    step_d = STEP4;
                end else begin
                    quarter_d = 1'b1;
                    half_d    = 1'b1;
                    irq_set_d = ~inhibit_q;
                    step_d    = STEP0;
                end
            end
            STEP4: begin
                quarter_d = 1'b1;
                half_d    = 1'b1;
                step_d    = STEP0;
            end
            default: begin
                step_d = STEP0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            prescaler_q <= '0;
            step_q      <= STEP0;
            mode_q      <= 1'b0;
            inhibit_q   <= 1'b0;
            quarter_q   <= 1'b0;
            half_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else if (iWrite) begin
            // A write restarts the sequence; any coincident tick is dropped.
            prescaler_q <= '0;
            step_q      <= STEP0;
            mode_q      <= iMode;
            inhibit_q   <= iIrq_inhibit;
`ifdef FRAME_IMMEDIATE_CLK_EN
            quarter_q   <= iMode;
            half_q      <= iMode;
`else
            quarter_q   <= 1'b0;
            half_q      <= 1'b0;
`endif
            if (iIrq_inhibit || iIrq_ack) begin
                irq_q <= 1'b0;
            end
        end else begin
            if (step_tick) begin
                prescaler_q <= '0;
                step_q      <= step_d;
                quarter_q   <= quarter_d;
                half_q      <= half_d;
            end else begin
                prescaler_q <= prescaler_q + DIV_W'(1);
                quarter_q   <= 1'b0;
                half_q      <= 1'b0;
            end
            // Set has priority over a simultaneous acknowledge.
            if (step_tick && irq_set_d) begin
                irq_q <= 1'b1;
            end else if (iIrq_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign oQuarter_clk = quarter_q;
    assign oHalf_clk    = half_q;
    assign oIrq         = irq_q;
    assign oStep        = step_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed self-checking bench for frame_sequencer
// with STEP_DIV=4.
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       iReset_n;
    logic       iWrite;
    logic       iMode;
    logic       iIrq_inhibit;
    logic       iIrq_ack;
    logic       oQuarter_clk;
    logic       oHalf_clk;
    logic       oIrq;
    logic [2:0] oStep;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_sequencer #(
        .STEP_DIV(4),
        .DIV_W   (3)
    ) dut (
        .clk         (clk),
        .iReset_n    (iReset_n),
        .iWrite      (iWrite),
        .iMode       (iMode),
        .iIrq_inhibit(iIrq_inhibit),
        .iIrq_ack    (iIrq_ack),
        .oQuarter_clk(oQuarter_clk),
        .oHalf_clk   (oHalf_clk),
        .oIrq        (oIrq),
        .oStep       (oStep)
    );

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic eq,
                           input logic eh, input logic ei,
                           input logic [2:0] es);
        chk({tag, "_q"}, {3'b0, oQuarter_clk}, {3'b0, eq});
        chk({tag, "_h"}, {3'b0, oHalf_clk}, {3'b0, eh});
        chk({tag, "_irq"}, {3'b0, oIrq}, {3'b0, ei});
        chk({tag, "_step"}, {1'b0, oStep}, {1'b0, es});
    endtask

    // Advance one step period; outputs must stay low until the last edge.
    task automatic period(input string tag, input bit ack,
                          input logic eq, input logic eh,
                          input logic ei, input logic [2:0] es);
        for (int i = 0; i < 4; i++) begin
            if (ack && i == 3) iIrq_ack = 1'b1;
            edge1();
            iIrq_ack = 1'b0;
            if (i < 3) begin
                chk({tag, "_gapq"}, {3'b0, oQuarter_clk}, 4'd0);
                chk({tag, "_gaph"}, {3'b0, oHalf_clk}, 4'd0);
            end
        end
        chk_all(tag, eq, eh, ei, es);
    endtask

    task automatic wr(input string tag, input logic m,
                      input logic inh, input logic ei);
        logic ep;
        iWrite       = 1'b1;
        iMode        = m;
        iIrq_inhibit = inh;
        edge1();
        iWrite       = 1'b0;
        iMode        = 1'b0;
        iIrq_inhibit = 1'b0;
`ifdef FRAME_IMMEDIATE_CLK_EN
        ep = m;
`else
        ep = 1'b0;
`endif
        chk_all(tag, ep, ep, ei, 3'd0);
    endtask

    initial begin
        iReset_n     = 1'b0;
        iWrite       = 1'b0;
        iMode        = 1'b0;
        iIrq_inhibit = 1'b0;
        iIrq_ack     = 1'b0;
        edge1();
        edge1();
        chk_all("rst", 1'b0, 1'b0, 1'b0, 3'd0);
        iReset_n = 1'b1;

        // 4-step sequence from reset release
        period("a_s0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        period("a_s1", 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        period("a_s2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
        period("a_s3", 1'b0, 1'b1, 1'b1, 1'b1, 3'd0);

        // ack on a step0 tick clears; IRQ returns at next step3
        period("b_s0", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
        period("b_s1", 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        period("b_s2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
        period("b_s3", 1'b0, 1'b1, 1'b1, 1'b1, 3'd0);

        // irq holds across wrap, then ack coinciding with step3 set
        period("c_s0", 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
        period("c_s1", 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        period("c_s2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
        period("c_s3", 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);

        // mid-sequence write with inhibit clears IRQ and restarts
        edge1();
        wr("d_wr", 1'b0, 1'b1, 1'b0);
        period("d_s0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        period("d_s1", 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        period("d_s2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
        period("d_s3", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);

        // 5-step mode, inhibited
        wr("e_wr", 1'b1, 1'b1, 1'b0);
        period("e_s0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        period("e_s1", 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        period("e_s2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
        period("e_s3", 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
        period("e_s4", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);

        // write on the prescaler terminal count drops the tick
        edge1();
        edge1();
        edge1();
        wr("f_wr", 1'b0, 1'b0, 1'b0);
        period("f_s0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);

        // reset overrides a simultaneous write
        iReset_n = 1'b0;
        iWrite   = 1'b1;
        iMode    = 1'b1;
        edge1();
        iWrite   = 1'b0;
        iMode    = 1'b0;
        chk_all("g_rst", 1'b0, 1'b0, 1'b0, 3'd0);
        iReset_n = 1'b1;
        period("g_s0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
